// File: rtl/cell_array_launcher_pkg.sv
// rtl/cell_array_launcher_pkg.sv - shared widths, FSM state encoding and program word layout
package cell_array_launcher_pkg;

  localparam int INSTR_DATA_W = 32;
  localparam int INSTR_ADDR_W = 6;
  localparam int INSTR_HOPS_W = 4;
  localparam int PROG_ADDR_W  = 10;
  localparam int TIMEOUT_W    = 20;
  localparam int DRAIN_CYC    = 16;

  typedef enum logic [2:0] {
    LS_IDLE     = 3'd0,
    LS_LOAD     = 3'd1,
    LS_DRAIN    = 3'd2,
    LS_CALL     = 3'd3,
    LS_WAIT_RET = 3'd4,
    LS_DONE     = 3'd5
  } launcher_state_e;

  typedef struct packed {
    logic [INSTR_HOPS_W-1:0] hops;
    logic [INSTR_ADDR_W-1:0] addr;
    logic [INSTR_DATA_W-1:0] data;
  } prog_word_t;

endpackage

// File: rtl/cell_array_launcher_if.sv
// rtl/cell_array_launcher_if.sv - program buffer read port plus cell array load/call/ret signals
interface cell_array_launcher_if import cell_array_launcher_pkg::*; #(
  parameter int INSTR_DATA_WIDTH = INSTR_DATA_W,
  parameter int INSTR_ADDR_WIDTH = INSTR_ADDR_W,
  parameter int INSTR_HOPS_WIDTH = INSTR_HOPS_W,
  parameter int PROG_ADDR_WIDTH  = PROG_ADDR_W
) ();

  localparam int WORD_W = INSTR_HOPS_WIDTH + INSTR_ADDR_WIDTH + INSTR_DATA_WIDTH;

  logic                        prog_rd_en;
  logic [PROG_ADDR_WIDTH-1:0]  prog_rd_addr;
  logic [WORD_W-1:0]           prog_rd_data;
  logic [INSTR_DATA_WIDTH-1:0] instr_data_out;
  logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out;
  logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out;
  logic                        instr_en_out;
  logic                        call_out;
  logic                        ret_in;

  modport master (
    output prog_rd_en, prog_rd_addr,
    input  prog_rd_data,
    output instr_data_out, instr_addr_out, instr_hops_out, instr_en_out, call_out,
    input  ret_in
  );

  modport slave (
    input  prog_rd_en, prog_rd_addr,
    output prog_rd_data,
    input  instr_data_out, instr_addr_out, instr_hops_out, instr_en_out, call_out,
    output ret_in
  );

endinterface

// File: rtl/launcher_load_pipe.sv
// rtl/launcher_load_pipe.sv - program buffer address sequencer and read-return register onto the load chain
module launcher_load_pipe import cell_array_launcher_pkg::*; #(
  parameter int INSTR_DATA_WIDTH = INSTR_DATA_W,
  parameter int INSTR_ADDR_WIDTH = INSTR_ADDR_W,
  parameter int INSTR_HOPS_WIDTH = INSTR_HOPS_W,
  parameter int PROG_ADDR_WIDTH  = PROG_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        launch,
  input  logic [PROG_ADDR_WIDTH:0]    len,
  output logic                        rd_en,
  output logic [PROG_ADDR_WIDTH-1:0]  rd_addr,
  input  logic [INSTR_HOPS_WIDTH+INSTR_ADDR_WIDTH+INSTR_DATA_WIDTH-1:0] rd_data,
  output logic                        last_rd,
  output logic                        pending,
  output logic [INSTR_DATA_WIDTH-1:0] instr_data,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_addr,
  output logic [INSTR_HOPS_WIDTH-1:0] instr_hops,
  output logic                        instr_en
);

  logic [PROG_ADDR_WIDTH-1:0] last_addr;
  logic                       rd_vld;
  logic [PROG_ADDR_WIDTH:0]   len_m1;

  assign len_m1  = len - {{PROG_ADDR_WIDTH{1'b0}}, 1'b1};
  assign last_rd = rd_en && (rd_addr == last_addr);
  assign pending = rd_en || rd_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      last_addr  <= '0;
      rd_vld     <= 1'b0;
      instr_en   <= 1'b0;
      instr_data <= '0;
      instr_addr <= '0;
      instr_hops <= '0;
    end else begin
      rd_vld   <= rd_en;
      instr_en <= rd_vld;
      // Fields are forced to zero whenever no word is being presented.
      {instr_hops, instr_addr, instr_data} <= rd_vld ? rd_data : '0;
      if (launch) begin
        rd_en     <= 1'b1;
        rd_addr   <= '0;
        last_addr <= len_m1[PROG_ADDR_WIDTH-1:0];
      end else if (rd_en) begin
        if (last_rd) begin
          rd_en   <= 1'b0;
          rd_addr <= '0;
        end else begin
          rd_addr <= rd_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cell_array_launcher.sv
// rtl/cell_array_launcher.sv - load/drain/call/ret sequencer; CELL_ARRAY_LAUNCHER_WATCHDOG_EN adds the ret watchdog
module cell_array_launcher import cell_array_launcher_pkg::*; #(
  parameter int INSTR_DATA_WIDTH = INSTR_DATA_W,
  parameter int INSTR_ADDR_WIDTH = INSTR_ADDR_W,
  parameter int INSTR_HOPS_WIDTH = INSTR_HOPS_W,
  parameter int PROG_ADDR_WIDTH  = PROG_ADDR_W,
  parameter int DRAIN_CYCLES     = DRAIN_CYC,
  parameter int TIMEOUT_WIDTH    = TIMEOUT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [PROG_ADDR_WIDTH:0] prog_len,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  cell_array_launcher_if.master    arr
);

  localparam logic [2:0] ST_IDLE     = 3'(LS_IDLE);
  localparam logic [2:0] ST_LOAD     = 3'(LS_LOAD);
  localparam logic [2:0] ST_DRAIN    = 3'(LS_DRAIN);
  localparam logic [2:0] ST_CALL     = 3'(LS_CALL);
  localparam logic [2:0] ST_WAIT_RET = 3'(LS_WAIT_RET);
  localparam logic [2:0] ST_DONE     = 3'(LS_DONE);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [PROG_ADDR_WIDTH:0] MAX_LEN = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};

  logic [2:0]               state;
  logic [DW-1:0]            drain_cnt;
  logic [PROG_ADDR_WIDTH:0] eff_len;
  logic                     launch, last_rd, pending, wd_fire;

  assign eff_len = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
  assign launch  = (state == ST_IDLE) && start && (prog_len != '0);

  launcher_load_pipe #(
    .INSTR_DATA_WIDTH (INSTR_DATA_WIDTH),
    .INSTR_ADDR_WIDTH (INSTR_ADDR_WIDTH),
    .INSTR_HOPS_WIDTH (INSTR_HOPS_WIDTH),
    .PROG_ADDR_WIDTH  (PROG_ADDR_WIDTH)
  ) u_load_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .launch     (launch),
    .len        (eff_len),
    .rd_en      (arr.prog_rd_en),
    .rd_addr    (arr.prog_rd_addr),
    .rd_data    (arr.prog_rd_data),
    .last_rd    (last_rd),
    .pending    (pending),
    .instr_data (arr.instr_data_out),
    .instr_addr (arr.instr_addr_out),
    .instr_hops (arr.instr_hops_out),
    .instr_en   (arr.instr_en_out)
  );

`ifdef CELL_ARRAY_LAUNCHER_WATCHDOG_EN
  logic [TIMEOUT_WIDTH-1:0] wd_limit, wd_cnt;

  assign wd_fire = (wd_limit != '0) && (wd_cnt == wd_limit - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_limit <= '0;
      wd_cnt   <= '0;
    end else begin
      if ((state == ST_IDLE) && start) wd_limit <= timeout_cycles;
      wd_cnt <= (state == ST_WAIT_RET) ? wd_cnt + 1'b1 : '0;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^timeout_cycles;
  assign wd_fire        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      drain_cnt    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      arr.call_out <= 1'b0;
    end else begin
      done         <= 1'b0;
      arr.call_out <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          busy        <= 1'b1;
          timeout_err <= 1'b0;
          drain_cnt   <= '0;
          state       <= (prog_len == '0) ? ST_DRAIN : ST_LOAD;
        end
        ST_LOAD: if (last_rd) state <= ST_DRAIN;
        // The quiet window starts once no read is in flight; its last cycle is the CALL state.
        ST_DRAIN: if (!pending) begin
          if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state <= ST_CALL;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        ST_CALL: begin
          arr.call_out <= 1'b1;
          state        <= ST_WAIT_RET;
        end
        ST_WAIT_RET: if (arr.ret_in || wd_fire) begin
          done        <= 1'b1;
          timeout_err <= !arr.ret_in;
          state       <= ST_DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_array_launcher.sv
// tb/tb_cell_array_launcher.sv - scoreboard bench for cell_array_launcher
module tb_cell_array_launcher;
  import cell_array_launcher_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] prog_len = '0;
  logic [19:0] timeout_cycles = '0;
  logic        busy, done, timeout_err;

  cell_array_launcher_if arr ();

  cell_array_launcher dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .prog_len       (prog_len),
    .timeout_cycles (timeout_cycles),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err),
    .arr            (arr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    int          cyc;
    logic [41:0] w;
  } ev_t;

  ev_t rd_q[$], in_q[$], call_q[$], done_q[$];

  function automatic prog_word_t img(int i);
    prog_word_t p;
    p.hops = 4'(i + 1);
    p.addr = 6'(i + 5);
    p.data = 32'(i + 10);
    return p;
  endfunction

  always @(posedge clk) if (arr.prog_rd_en) arr.prog_rd_data <= img(int'(arr.prog_rd_addr));

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc=%0d)", n, act, exp, cyc);
    end
  endtask

  task automatic cmp_ev(string n, int sz, ev_t e, logic [41:0] act);
    if (sz == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected actual=%0h required=none (cyc=%0d)", n, act, cyc);
    end else begin
      chk({n, "_cycle"}, 64'(cyc), 64'(e.cyc));
      chk(n, 64'(act), 64'(e.w));
    end
  endtask

  // Monitor: every presented output pops the matching expectation.
  always @(negedge clk) begin : mon
    ev_t e;
    int  sz;
    if (arr.prog_rd_en) begin
      e = '0; sz = rd_q.size();
      if (sz > 0) e = rd_q.pop_front();
      cmp_ev("rd_addr", sz, e, 42'(arr.prog_rd_addr));
    end
    if (arr.instr_en_out) begin
      e = '0; sz = in_q.size();
      if (sz > 0) e = in_q.pop_front();
      cmp_ev("instr", sz, e, {arr.instr_hops_out, arr.instr_addr_out, arr.instr_data_out});
    end else if ({arr.instr_hops_out, arr.instr_addr_out, arr.instr_data_out} != '0) begin
      chk("instr_zero", 64'({arr.instr_hops_out, arr.instr_addr_out, arr.instr_data_out}), 64'd0);
    end
    if (arr.call_out) begin
      e = '0; sz = call_q.size();
      if (sz > 0) e = call_q.pop_front();
      cmp_ev("call", sz, e, 42'd1);
    end
    if (done) begin
      e = '0; sz = done_q.size();
      if (sz > 0) e = done_q.pop_front();
      cmp_ev("done_err", sz, e, 42'(timeout_err));
    end
  end

  // Cycle j after the start edge is seen while cyc == base + j - 1.
  task automatic launch(int len, int tmo, output int base);
    @(posedge clk); #1;
    start = 1'b1; prog_len = 11'(len); timeout_cycles = 20'(tmo);
    base = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic goto(int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic push_load(int b, int n);
    for (int i = 0; i < n; i++) begin
      rd_q.push_back('{cyc: b + i, w: 42'(i)});
      in_q.push_back('{cyc: b + 2 + i, w: img(i)});
    end
  endtask

  task automatic push_end(int b, int call_c, int done_c, logic err);
    call_q.push_back('{cyc: b + call_c - 1, w: 42'd1});
    if (done_c > 0) done_q.push_back('{cyc: b + done_c - 1, w: 42'(err)});
  endtask

  task automatic finish_run(string n, int b, int done_c, int bound);
    int k = 0;
    while (busy && k < bound) begin @(posedge clk); #1; k++; end
    chk({n, "_idle"}, 64'(busy), 64'd0);
    chk({n, "_busy_fall"}, 64'(cyc), 64'(b + done_c));
    repeat (2) @(posedge clk);
    #1;
    chk({n, "_queues_empty"}, 64'(rd_q.size() + in_q.size() + call_q.size() + done_q.size()), 64'd0);
  endtask

  initial begin
    int b;
    arr.ret_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({busy, done, timeout_err, arr.prog_rd_en, arr.prog_rd_addr, arr.instr_en_out,
        arr.instr_data_out, arr.instr_addr_out, arr.instr_hops_out, arr.call_out}), 64'd0);
    rst_n = 1'b1;

    // Three-word image, ret at cycle 30.
    launch(3, 0, b);
    chk("t1_busy_c1", 64'(busy), 64'd1);
    push_load(b, 3);
    push_end(b, 22, 31, 1'b0);
    goto(b + 29);
    arr.ret_in = 1'b1;
    finish_run("t1", b, 31, 100);
    arr.ret_in = 1'b0;

    // Empty image: straight to drain.
    launch(0, 0, b);
    push_end(b, 18, 26, 1'b0);
    goto(b + 24);
    arr.ret_in = 1'b1;
    finish_run("t2", b, 26, 100);
    arr.ret_in = 1'b0;

    // ret held high across load and drain.
    arr.ret_in = 1'b1;
    launch(2, 0, b);
    push_load(b, 2);
    push_end(b, 21, 22, 1'b0);
    finish_run("t3", b, 22, 100);
    arr.ret_in = 1'b0;

`ifdef CELL_ARRAY_LAUNCHER_WATCHDOG_EN
    launch(0, 100, b);
    push_end(b, 18, 118, 1'b1);
    finish_run("t4_wd", b, 118, 300);
    chk("t4_err_held", 64'(timeout_err), 64'd1);
`else
    launch(0, 100, b);
    push_end(b, 18, 0, 1'b0);
    goto(b + 160);
    chk("t4_still_busy", 64'(busy), 64'd1);
    arr.ret_in = 1'b1;
    done_q.push_back('{cyc: b + 161, w: 42'd0});
    finish_run("t4_nowd", b, 162, 100);
    arr.ret_in = 1'b0;
`endif

    // Second start during LOAD is ignored.
    launch(4, 0, b);
    chk("t5_err_cleared", 64'(timeout_err), 64'd0);
    push_load(b, 4);
    push_end(b, 23, 27, 1'b0);
    goto(b + 1);
    start = 1'b1; prog_len = 11'd7;
    @(posedge clk); #1;
    start = 1'b0;
    goto(b + 25);
    arr.ret_in = 1'b1;
    finish_run("t5", b, 27, 100);
    arr.ret_in = 1'b0;

    // Reset in the middle of LOAD abandons the load.
    launch(8, 0, b);
    rd_q.push_back('{cyc: b, w: 42'd0});
    rd_q.push_back('{cyc: b + 1, w: 42'd1});
    rd_q.push_back('{cyc: b + 2, w: 42'd2});
    in_q.push_back('{cyc: b + 2, w: img(0)});
    goto(b + 3);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", 64'({busy, done, timeout_err, arr.prog_rd_en, arr.prog_rd_addr, arr.instr_en_out,
        arr.instr_data_out, arr.instr_addr_out, arr.instr_hops_out, arr.call_out}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_idle_after_reset", 64'(busy), 64'd0);
    chk("t6_queues_empty", 64'(rd_q.size() + in_q.size()), 64'd0);
    launch(2, 0, b);
    push_load(b, 2);
    push_end(b, 21, 26, 1'b0);
    goto(b + 24);
    arr.ret_in = 1'b1;
    finish_run("t6", b, 26, 100);
    arr.ret_in = 1'b0;

    // Oversized prog_len is clamped to the full buffer.
    launch(1500, 0, b);
    push_load(b, 1024);
    push_end(b, 1043, 1051, 1'b0);
    goto(b + 1049);
    arr.ret_in = 1'b1;
    finish_run("t7", b, 1051, 2000);
    arr.ret_in = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
